// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multiply/divide occupancy sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Which priority level is steering the pipeline controls this cycle.
  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_MEM,
    CAUSE_MD,
    CAUSE_LU,
    CAUSE_BR
  } hazard_cause_e;

  localparam int         DEF_MULT_LATENCY = 4;
  localparam int         DEF_DIV_LATENCY  = 33;
  localparam logic [4:0] REG_ZERO         = 5'd0;

  function automatic logic reg_match(input logic       uses,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Multiply/divide occupancy sequencer: tracks how long EX is held by a
// multi-cycle operation and pulses done on its final busy cycle.
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int DIV_LATENCY  = DEF_DIV_LATENCY,
  parameter int CNT_W        = $clog2(DIV_LATENCY + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_div_i,
  input  logic mem_wait_i,
  output logic busy_o,
  output logic done_o
);

  // The start cycle and the done cycle are both busy, hence the -2.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 2);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;

  // NOTE: sequential state uses non-blocking assignments; reset is sampled
  // on the clock edge, so it is an ordinary branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !mem_wait_i) begin
          state_d = MD_BUSY;
          cnt_d   = is_div_i ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (!mem_wait_i) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = rst && ((state_q == MD_BUSY) || (state_q == IDLE && start_i));
  assign done_o = rst && done_d;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Optional cause counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int DIV_LATENCY  = DEF_DIV_LATENCY,
  parameter int CNT_W        = $clog2(DIV_LATENCY + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_Rs,
  input  logic [4:0]  id_Rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        ex_branch_taken,
  input  logic        mem_wait,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic        md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_md_cnt,
  output logic [31:0] perf_mem_cnt
`endif
);

  logic          lu;
  hazard_cause_e cause;

  md_seq #(
    .MULT_LATENCY (MULT_LATENCY),
    .DIV_LATENCY  (DIV_LATENCY),
    .CNT_W        (CNT_W)
  ) u_md_seq (
    .clk        (clk),
    .rst        (rst),
    .start_i    (ex_md_start),
    .is_div_i   (ex_md_is_div),
    .mem_wait_i (mem_wait),
    .busy_o     (md_busy),
    .done_o     (md_done)
  );

  assign lu = ex_MemRead && (ex_wreg != REG_ZERO) &&
              (reg_match(id_uses_rs, id_Rs, ex_wreg) ||
               reg_match(id_uses_rt, id_Rt, ex_wreg));

  // On the done cycle the mult/div releases EX, so lower levels may act.
  always_comb begin
    cause = CAUSE_NONE;
    if (!rst)                     cause = CAUSE_NONE;
    else if (mem_wait)            cause = CAUSE_MEM;
    else if (md_busy && !md_done) cause = CAUSE_MD;
    else if (lu)                  cause = CAUSE_LU;
    else if (ex_branch_taken)     cause = CAUSE_BR;
  end

  // Exactly one level drives the controls, so a register never sees both
  // its stall and its flush in the same cycle.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (cause)
      CAUSE_MEM: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
      end
      CAUSE_MD: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end
      CAUSE_LU: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      CAUSE_BR: if_id_flush = 1'b1;
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_md_q, perf_mem_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_lu_q  <= '0;
      perf_md_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      if (cause == CAUSE_LU)  perf_lu_q  <= perf_lu_q + 32'd1;
      if (cause == CAUSE_MD)  perf_md_q  <= perf_md_q + 32'd1;
      if (cause == CAUSE_MEM) perf_mem_q <= perf_mem_q + 32'd1;
    end
  end

  assign perf_lu_cnt  = perf_lu_q;
  assign perf_md_cnt  = perf_md_q;
  assign perf_mem_cnt = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

  localparam int MULT_L = 4;
  localparam int DIV_L  = 33;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_Rs, id_Rt, ex_wreg;
  logic       id_uses_rs, id_uses_rt, ex_MemRead;
  logic       ex_md_start, ex_md_is_div, ex_branch_taken, mem_wait;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic       id_ex_flush, ex_mem_flush, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_cnt, perf_md_cnt, perf_mem_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_Rs           (id_Rs),
    .id_Rt           (id_Rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_MemRead      (ex_MemRead),
    .ex_wreg         (ex_wreg),
    .ex_md_start     (ex_md_start),
    .ex_md_is_div    (ex_md_is_div),
    .ex_branch_taken (ex_branch_taken),
    .mem_wait        (mem_wait),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .md_busy         (md_busy),
    .md_done         (md_done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lu_cnt     (perf_lu_cnt),
    .perf_md_cnt     (perf_md_cnt),
    .perf_mem_cnt    (perf_mem_cnt)
`endif
  );

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic md_busy;
    logic md_done;
  } out_t;

  out_t        obs;
  int          md_rem;   // busy cycles still owed by the mult/div, current included
  logic [31:0] m_lu, m_md, m_mem;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference: cause = 1 mem, 2 md, 3 lu, 4 branch, 0 none.
  function automatic void model(output out_t e, output int cause);
    logic lu, busy, done;
    e     = '0;
    cause = 0;
    if (!rst) return;
    busy = (md_rem > 0) || ex_md_start;
    done = (md_rem == 1) && !mem_wait;
    lu   = ex_MemRead && (ex_wreg != 5'd0) &&
           ((id_uses_rs && id_Rs == ex_wreg) || (id_uses_rt && id_Rt == ex_wreg));
    e.md_busy = busy;
    e.md_done = done;
    if (mem_wait) begin
      cause = 1;
      e.pc_stall = 1'b1; e.if_id_stall = 1'b1; e.id_ex_stall = 1'b1;
    end else if (busy && !done) begin
      cause = 2;
      e.pc_stall = 1'b1; e.if_id_stall = 1'b1; e.id_ex_stall = 1'b1;
      e.ex_mem_flush = 1'b1;
    end else if (lu) begin
      cause = 3;
      e.pc_stall = 1'b1; e.if_id_stall = 1'b1; e.id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      cause = 4;
      e.if_id_flush = 1'b1;
    end
  endfunction

  task automatic tick();
    out_t e;
    int   c;
    @(negedge clk);
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_flush, md_busy, md_done};
    model(e, c);
    check("outs", 32'(obs), 32'(e));
`ifdef HAZARD_PERF_CNT_EN
    check("perf_lu", perf_lu_cnt, m_lu);
    check("perf_md", perf_md_cnt, m_md);
    check("perf_mem", perf_mem_cnt, m_mem);
`endif
    @(posedge clk);
    if (!rst) begin
      md_rem = 0;
      m_lu = '0; m_md = '0; m_mem = '0;
    end else begin
      case (c)
        1: m_mem = m_mem + 32'd1;
        2: m_md  = m_md + 32'd1;
        3: m_lu  = m_lu + 32'd1;
        default: ;
      endcase
      if (!mem_wait) begin
        if (md_rem > 0) md_rem = md_rem - 1;
        else if (ex_md_start) md_rem = (ex_md_is_div ? DIV_L : MULT_L) - 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_Rs = '0; id_Rt = '0; ex_wreg = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_MemRead = 1'b0;
    ex_md_start = 1'b0; ex_md_is_div = 1'b0; ex_branch_taken = 1'b0;
    mem_wait = 1'b0;
  endtask

  // One-cycle start pulse, optional 3-cycle mem_wait window from wait_at.
  task automatic run_md(input logic is_div, input int wait_at, input int n,
                        output int busy_n, output int done_at,
                        output int flush_n, output int done_n);
    busy_n = 0; done_at = 0; flush_n = 0; done_n = 0;
    ex_md_start  = 1'b1;
    ex_md_is_div = is_div;
    for (int i = 1; i <= n; i++) begin
      mem_wait = (wait_at > 0) && (i >= wait_at) && (i < wait_at + 3);
      tick();
      if (obs.md_busy) busy_n++;
      if (obs.md_done) begin done_n++; done_at = i; end
      if (obs.ex_mem_flush) flush_n++;
      ex_md_start = 1'b0;
    end
    mem_wait = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   busy_n, done_at, flush_n, done_n;
    out_t br_e;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] md0, mem0;
`endif
    md_rem = 0;
    m_lu = '0; m_md = '0; m_mem = '0;
    clear_inputs();
    rst = 1'b0;
    tick();
    check("reset_outs", 32'(obs), 32'd0);
    rst = 1'b1;
    tick();

    // Load-use on Rs: exactly one stall cycle, then the load has moved on.
    id_Rs = 5'd5; id_uses_rs = 1'b1; ex_MemRead = 1'b1; ex_wreg = 5'd5;
    tick();
    check("lu_stall", 32'({obs.pc_stall, obs.if_id_stall, obs.id_ex_flush}), 32'd7);
    ex_MemRead = 1'b0;
    tick();
    check("lu_release", 32'(obs.pc_stall), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_lu_one", perf_lu_cnt, 32'd1);
`endif
    id_Rs = 5'd0; ex_wreg = 5'd0; ex_MemRead = 1'b1;
    tick();
    check("lu_r0", 32'({obs.pc_stall, obs.if_id_stall, obs.id_ex_flush}), 32'd0);
    clear_inputs();

    // Divide, then multiply occupancy.
`ifdef HAZARD_PERF_CNT_EN
    md0 = perf_md_cnt;
`endif
    run_md(1'b1, 0, 40, busy_n, done_at, flush_n, done_n);
    check("div_busy", 32'(busy_n), 32'd33);
    check("div_done_at", 32'(done_at), 32'd33);
    check("div_flush", 32'(flush_n), 32'd32);
    check("div_done_n", 32'(done_n), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_md_div", perf_md_cnt - md0, 32'd32);
`endif
    run_md(1'b0, 0, 8, busy_n, done_at, flush_n, done_n);
    check("mul_busy", 32'(busy_n), 32'd4);
    check("mul_done_at", 32'(done_at), 32'd4);
    check("mul_flush", 32'(flush_n), 32'd3);

    // Divide with a 3-cycle memory wait mid-count.
`ifdef HAZARD_PERF_CNT_EN
    md0 = perf_md_cnt; mem0 = perf_mem_cnt;
`endif
    run_md(1'b1, 10, 45, busy_n, done_at, flush_n, done_n);
    check("divw_busy", 32'(busy_n), 32'd36);
    check("divw_done_at", 32'(done_at), 32'd36);
    check("divw_flush", 32'(flush_n), 32'd32);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_md_divw", perf_md_cnt - md0, 32'd32);
    check("perf_mem_divw", perf_mem_cnt - mem0, 32'd3);
`endif

    // Taken branch alone, then deferred by mem_wait.
    ex_branch_taken = 1'b1;
    tick();
    br_e = '0;
    br_e.if_id_flush = 1'b1;
    check("br_only", 32'(obs), 32'(br_e));
    mem_wait = 1'b1;
    tick();
    check("br_wait1", 32'(obs.if_id_flush), 32'd0);
    tick();
    check("br_wait2", 32'(obs.if_id_flush), 32'd0);
    mem_wait = 1'b0;
    tick();
    check("br_release", 32'(obs.if_id_flush), 32'd1);
    clear_inputs();

    // Reset at busy cycle 10 of a divide.
    ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      ex_md_start = 1'b0;
    end
    rst = 1'b0;
    tick();
    check("rst_mid_outs", 32'(obs), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_after", 32'({obs.md_busy, obs.md_done}), 32'd0);
    run_md(1'b1, 0, 40, busy_n, done_at, flush_n, done_n);
    check("rst_fresh_busy", 32'(busy_n), 32'd33);
    check("rst_fresh_done", 32'(done_at), 32'd33);
    clear_inputs();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      rst             = ($urandom_range(0, 63) != 0);
      id_Rs           = 5'($urandom_range(0, 3));
      id_Rt           = 5'($urandom_range(0, 3));
      ex_wreg         = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_MemRead      = ($urandom_range(0, 2) == 0);
      ex_md_start     = ($urandom_range(0, 11) == 0);
      ex_md_is_div    = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_wait        = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
